ifm_skew_feeder: RTL and testbench

Upstream stage of the binary-serial Eyeriss-style PE array. It accepts one HEIGHT-wide input-feature-map vector per handshake and holds each value for MAC_CYC cycles, one serial MAC. It generates the per-row en_i, clr_i and mac_done controls and skews every row h by h cycles, so each row's data and controls reach the row's border PE aligned with the systolic wavefront. Its outputs connect directly to the array's en_i, clr_i, mac_done and ifm row inputs.

---
 rtl/ifm_skew_feeder.sv | 130 +++++++++++++
 tb/tb_ifm_skew_feeder.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ifm_skew_feeder.sv
// rtl/ifm_skew_feeder.sv - holds each ifm vector for MAC_CYC cycles and skews row h by h cycles
// toward the PE array border, generating the per-row en/clr/done controls alongside the operand.
module ifm_skew_feeder #(
   parameter int HEIGHT  = 12,
   parameter int IWIDTH  = 8,
   parameter int MAC_CYC = 8
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic signed [IWIDTH-1:0] in_ifm [HEIGHT],
   input  logic                     in_last,
   output logic [HEIGHT-1:0]        en_i,
   output logic [HEIGHT-1:0]        clr_i,
   output logic [HEIGHT-1:0]        mac_done,
   output logic signed [IWIDTH-1:0] ifm [HEIGHT],
   output logic                     busy
);

   localparam int CW = (MAC_CYC > 1) ? $clog2(MAC_CYC) : 1;
   localparam logic [CW-1:0] LAST_CNT = CW'(MAC_CYC - 1);

   typedef enum logic {S_IDLE, S_HOLD} state_t;

   state_t                  r_state, w_state_nxt;
   logic [CW-1:0]           r_cnt, w_cnt_nxt;
   logic                    r_first, w_first_nxt;
   logic                    r_lastf;
   logic signed [IWIDTH-1:0] r_hold [HEIGHT];
   logic                    w_load;
   logic                    w_accept;
   logic                    w_cnt_last;
   logic                    w_s_en, w_s_clr, w_s_done;
   logic [HEIGHT-1:0]       w_row_busy;

   assign w_cnt_last = (r_cnt == LAST_CNT);
   // Ready at the last hold cycle too, so consecutive vectors leave no bubble.
   assign in_ready   = !rst && ((r_state == S_IDLE) || ((r_state == S_HOLD) && w_cnt_last));
   assign w_accept   = in_valid & in_ready;

   assign w_s_en   = (r_state == S_HOLD);
   assign w_s_clr  = w_s_en & (r_cnt == '0) & r_first;
   assign w_s_done = w_s_en & w_cnt_last & r_lastf;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_first <= 1'b1;
         r_lastf <= 1'b0;
         for (int h = 0; h < HEIGHT; h++) r_hold[h] <= '0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_first <= w_first_nxt;
         if (w_load) begin
            r_lastf <= in_last;
            r_hold  <= in_ifm;
         end
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      w_first_nxt = r_first;
      w_load      = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_accept) begin
               w_state_nxt = S_HOLD;
               w_cnt_nxt   = '0;
               w_load      = 1'b1;
            end
         end
         S_HOLD: begin
            if (w_cnt_last) begin
               // first tracks accumulation boundaries, surviving idle gaps.
               w_first_nxt = r_lastf;
               w_cnt_nxt   = '0;
               if (w_accept) begin
                  w_state_nxt = S_HOLD;
                  w_load      = 1'b1;
               end else begin
                  w_state_nxt = S_IDLE;
               end
            end else begin
               w_cnt_nxt = r_cnt + 1'b1;
            end
         end
         default: w_state_nxt = S_IDLE;
      endcase
   end

   for (genvar h = 0; h < HEIGHT; h++) begin : g_row
      localparam int D = h + 1;
      logic [D-1:0]             r_en, r_clr, r_done;
      logic signed [IWIDTH-1:0] r_dat [D];

      always_ff @(posedge clk) begin
         if (rst) begin
            r_en   <= '0;
            r_clr  <= '0;
            r_done <= '0;
            for (int s = 0; s < D; s++) r_dat[s] <= '0;
         end else begin
            r_en[0]   <= w_s_en;
            r_clr[0]  <= w_s_clr;
            r_done[0] <= w_s_done;
            r_dat[0]  <= w_s_en ? r_hold[h] : '0;
            for (int s = 1; s < D; s++) begin
               r_en[s]   <= r_en[s-1];
               r_clr[s]  <= r_clr[s-1];
               r_done[s] <= r_done[s-1];
               r_dat[s]  <= r_dat[s-1];
            end
         end
      end

      assign en_i[h]       = r_en[D-1];
      assign clr_i[h]      = r_clr[D-1];
      assign mac_done[h]   = r_done[D-1];
      assign ifm[h]        = r_dat[D-1];
      assign w_row_busy[h] = |r_en;
   end

   assign busy = (r_state == S_HOLD) | (|w_row_busy);

endmodule

// File: tb/tb_ifm_skew_feeder.sv
// tb/tb_ifm_skew_feeder.sv - directed self-checking bench for ifm_skew_feeder
module tb_ifm_skew_feeder;

   localparam int H = 4;
   localparam int W = 8;
   localparam int M = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                rst;
   logic                in_valid, in_last, in_ready, busy;
   logic signed [W-1:0] in_ifm [H];
   logic [H-1:0]        en_i, clr_i, mac_done;
   logic signed [W-1:0] ifm [H];

   logic                v1_valid, v1_last, v1_ready, v1_busy;
   logic signed [W-1:0] v1_ifm [H];
   logic [H-1:0]        v1_en, v1_clr, v1_done;
   logic signed [W-1:0] v1_ifmo [H];

   int n_checks = 0;
   int n_fail   = 0;

   ifm_skew_feeder #(.HEIGHT(H), .IWIDTH(W), .MAC_CYC(M)) u_dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_ifm(in_ifm),
      .in_last(in_last), .en_i(en_i), .clr_i(clr_i), .mac_done(mac_done), .ifm(ifm), .busy(busy)
   );

   ifm_skew_feeder #(.HEIGHT(H), .IWIDTH(W), .MAC_CYC(1)) u_dut1 (
      .clk(clk), .rst(rst), .in_valid(v1_valid), .in_ready(v1_ready), .in_ifm(v1_ifm),
      .in_last(v1_last), .en_i(v1_en), .clr_i(v1_clr), .mac_done(v1_done), .ifm(v1_ifmo),
      .busy(v1_busy)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      for (int c = 0; c < 3; c++) begin
         tick();
         n_checks++;
         if (en_i !== '0 || clr_i !== '0 || mac_done !== '0 || busy !== 1'b0 || in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctl c=%0d got en=%b clr=%b done=%b busy=%b rdy=%b exp all 0",
                     c, en_i, clr_i, mac_done, busy, in_ready);
         end
         for (int h = 0; h < H; h++) begin
            n_checks++;
            if (ifm[h] !== '0) begin
               n_fail++;
               $display("FAIL reset_ifm c=%0d h=%0d got %0d exp 0", c, h, ifm[h]);
            end
         end
      end
      rst = 1'b0;
      tick();
      n_checks++;
      if (in_ready !== 1'b1 || busy !== 1'b0 || v1_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_release got rdy=%b busy=%b rdy1=%b exp 1 0 1", in_ready, busy, v1_ready);
      end
   endtask

   task automatic test_single();
      logic signed [W-1:0] v [H];
      logic signed [W-1:0] e_ifm [H];
      logic [H-1:0]        e_en, e_clr, e_done;
      v = '{8'sd1, -8'sd2, 8'sd3, 8'sd4};
      in_ifm = v; in_last = 1'b1; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int k = 0; k <= 9; k++) begin
         for (int h = 0; h < H; h++) begin
            e_en[h]   = (k >= 1 + h) && (k <= M + h);
            e_clr[h]  = (k == 1 + h);
            e_done[h] = (k == M + h);
            e_ifm[h]  = e_en[h] ? v[h] : '0;
         end
         n_checks++;
         if (en_i !== e_en || clr_i !== e_clr || mac_done !== e_done) begin
            n_fail++;
            $display("FAIL single_ctl k=%0d got en=%b clr=%b done=%b exp en=%b clr=%b done=%b",
                     k, en_i, clr_i, mac_done, e_en, e_clr, e_done);
         end
         n_checks++;
         if (busy !== (k <= M + H - 1) || in_ready !== (k >= M - 1)) begin
            n_fail++;
            $display("FAIL single_busy k=%0d got busy=%b rdy=%b exp busy=%b rdy=%b",
                     k, busy, in_ready, (k <= M + H - 1), (k >= M - 1));
         end
         for (int h = 0; h < H; h++) begin
            n_checks++;
            if (ifm[h] !== e_ifm[h]) begin
               n_fail++;
               $display("FAIL single_ifm k=%0d h=%0d got %0d exp %0d", k, h, ifm[h], e_ifm[h]);
            end
         end
         tick();
      end
   endtask

   task automatic test_back_to_back();
      logic signed [W-1:0] a [H];
      logic signed [W-1:0] b [H];
      logic signed [W-1:0] c [H];
      logic signed [W-1:0] e_ifm [H];
      logic [H-1:0]        e_en, e_clr, e_done;
      logic                e_rdy;
      int                  idx;
      a = '{8'sd5, 8'sd6, 8'sd7, 8'sd8};
      b = '{-8'sd1, -8'sd3, -8'sd5, -8'sd7};
      c = '{8'sd9, 8'sd10, 8'sd11, 8'sd12};
      in_ifm = a; in_last = 1'b0; in_valid = 1'b1;
      tick();
      in_ifm = b;
      for (int k = 0; k <= 16; k++) begin
         for (int h = 0; h < H; h++) begin
            e_en[h]   = (k >= 1 + h) && (k <= 12 + h);
            e_clr[h]  = (k == 1 + h);
            e_done[h] = (k == 12 + h);
            idx       = (k - 1 - h) / 4;
            e_ifm[h]  = !e_en[h] ? '0 : (idx == 0) ? a[h] : (idx == 1) ? b[h] : c[h];
         end
         e_rdy = ((k % 4) == 3) || (k >= 12);
         n_checks++;
         if (en_i !== e_en || clr_i !== e_clr || mac_done !== e_done) begin
            n_fail++;
            $display("FAIL b2b_ctl k=%0d got en=%b clr=%b done=%b exp en=%b clr=%b done=%b",
                     k, en_i, clr_i, mac_done, e_en, e_clr, e_done);
         end
         n_checks++;
         if (in_ready !== e_rdy || busy !== (k <= 15)) begin
            n_fail++;
            $display("FAIL b2b_rdy k=%0d got rdy=%b busy=%b exp rdy=%b busy=%b",
                     k, in_ready, busy, e_rdy, (k <= 15));
         end
         for (int h = 0; h < H; h++) begin
            n_checks++;
            if (ifm[h] !== e_ifm[h]) begin
               n_fail++;
               $display("FAIL b2b_ifm k=%0d h=%0d got %0d exp %0d", k, h, ifm[h], e_ifm[h]);
            end
         end
         if (k == 4) begin
            in_ifm = c; in_last = 1'b1;
         end
         if (k == 8) in_valid = 1'b0;
         tick();
      end
   endtask

   task automatic test_gap();
      logic signed [W-1:0] a [H];
      logic signed [W-1:0] b [H];
      logic signed [W-1:0] e_ifm [H];
      logic [H-1:0]        e_en, e_clr, e_done;
      logic                ea, eb, e_rdy;
      a = '{8'sd11, -8'sd12, 8'sd13, -8'sd14};
      b = '{8'sd21, 8'sd22, 8'sd23, 8'sd24};
      in_ifm = a; in_last = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int k = 0; k <= 14; k++) begin
         for (int h = 0; h < H; h++) begin
            ea        = (k >= 1 + h) && (k <= 4 + h);
            eb        = (k >= 7 + h) && (k <= 10 + h);
            e_en[h]   = ea | eb;
            e_clr[h]  = (k == 1 + h);
            e_done[h] = (k == 10 + h);
            e_ifm[h]  = ea ? a[h] : eb ? b[h] : '0;
         end
         e_rdy = !((k <= 2) || ((k >= 6) && (k <= 8)));
         n_checks++;
         if (en_i !== e_en || clr_i !== e_clr || mac_done !== e_done) begin
            n_fail++;
            $display("FAIL gap_ctl k=%0d got en=%b clr=%b done=%b exp en=%b clr=%b done=%b",
                     k, en_i, clr_i, mac_done, e_en, e_clr, e_done);
         end
         n_checks++;
         if (in_ready !== e_rdy || busy !== (k <= 13)) begin
            n_fail++;
            $display("FAIL gap_rdy k=%0d got rdy=%b busy=%b exp rdy=%b busy=%b",
                     k, in_ready, busy, e_rdy, (k <= 13));
         end
         for (int h = 0; h < H; h++) begin
            n_checks++;
            if (ifm[h] !== e_ifm[h]) begin
               n_fail++;
               $display("FAIL gap_ifm k=%0d h=%0d got %0d exp %0d", k, h, ifm[h], e_ifm[h]);
            end
         end
         if (k == 5) begin
            in_ifm = b; in_last = 1'b1; in_valid = 1'b1;
         end
         if (k == 6) in_valid = 1'b0;
         tick();
      end
   endtask

   task automatic test_reset_mid();
      logic signed [W-1:0] v [H];
      logic [H-1:0]        e_en, e_clr;
      v = '{8'sd31, 8'sd32, 8'sd33, 8'sd34};
      in_ifm = v; in_last = 1'b1; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int k = 0; k <= 3; k++) begin
         for (int h = 0; h < H; h++) e_en[h] = (k >= 1 + h) && (k <= M + h);
         n_checks++;
         if (en_i !== e_en) begin
            n_fail++;
            $display("FAIL rstmid_pre k=%0d got en=%b exp %b", k, en_i, e_en);
         end
         if (k < 3) tick();
      end
      rst = 1'b1;
      tick();
      n_checks++;
      if (en_i !== '0 || clr_i !== '0 || mac_done !== '0 || busy !== 1'b0 || ifm[2] !== '0) begin
         n_fail++;
         $display("FAIL rstmid_clear got en=%b clr=%b done=%b busy=%b ifm2=%0d exp all 0",
                  en_i, clr_i, mac_done, busy, ifm[2]);
      end
      rst = 1'b0;
      for (int k = 0; k < 6; k++) begin
         tick();
         n_checks++;
         if (mac_done !== '0 || en_i !== '0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rstmid_quiet k=%0d got done=%b en=%b busy=%b exp 0 0 0",
                     k, mac_done, en_i, busy);
         end
      end
      v = '{8'sd41, 8'sd42, 8'sd43, 8'sd44};
      in_ifm = v; in_last = 1'b0; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      for (int k = 0; k <= 8; k++) begin
         for (int h = 0; h < H; h++) begin
            e_en[h]  = (k >= 1 + h) && (k <= M + h);
            e_clr[h] = (k == 1 + h);
         end
         n_checks++;
         if (en_i !== e_en || clr_i !== e_clr || mac_done !== '0) begin
            n_fail++;
            $display("FAIL rstmid_next k=%0d got en=%b clr=%b done=%b exp en=%b clr=%b done=0",
                     k, en_i, clr_i, mac_done, e_en, e_clr);
         end
         tick();
      end
   endtask

   task automatic test_mac1();
      logic signed [W-1:0] e_ifm [H];
      logic [H-1:0]        e_en;
      for (int h = 0; h < H; h++) v1_ifm[h] = W'(h + 1);
      v1_last = 1'b1; v1_valid = 1'b1;
      tick();
      for (int k = 0; k <= 12; k++) begin
         for (int h = 0; h < H; h++) begin
            e_en[h]  = (k >= 1 + h) && (k <= 8 + h);
            e_ifm[h] = e_en[h] ? W'((k - 1 - h) * 4 + h + 1) : '0;
         end
         n_checks++;
         if (v1_en !== e_en || v1_clr !== e_en || v1_done !== e_en) begin
            n_fail++;
            $display("FAIL mac1_ctl k=%0d got en=%b clr=%b done=%b exp all %b",
                     k, v1_en, v1_clr, v1_done, e_en);
         end
         n_checks++;
         if (v1_ready !== 1'b1 || v1_busy !== (k <= 11)) begin
            n_fail++;
            $display("FAIL mac1_rdy k=%0d got rdy=%b busy=%b exp rdy=1 busy=%b",
                     k, v1_ready, v1_busy, (k <= 11));
         end
         for (int h = 0; h < H; h++) begin
            n_checks++;
            if (v1_ifmo[h] !== e_ifm[h]) begin
               n_fail++;
               $display("FAIL mac1_ifm k=%0d h=%0d got %0d exp %0d", k, h, v1_ifmo[h], e_ifm[h]);
            end
         end
         if (k < 7) begin
            for (int h = 0; h < H; h++) v1_ifm[h] = W'((k + 1) * 4 + h + 1);
         end else begin
            v1_valid = 1'b0;
         end
         tick();
      end
   endtask

   initial begin
      rst = 1'b1;
      in_valid = 1'b0; in_last = 1'b0;
      v1_valid = 1'b0; v1_last = 1'b0;
      for (int h = 0; h < H; h++) begin
         in_ifm[h] = '0;
         v1_ifm[h] = '0;
      end
      test_reset();
      test_single();
      test_back_to_back();
      test_gap();
      test_reset_mid();
      test_mac1();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
